sev_seg_scan_decoder: RTL and testbench
=======================================

Name: sev_seg_scan_decoder

Overview:
Reader for the multiplexed Basys-3 seven-segment bus. It watches the active-low anode strobes and cathode patterns that the display driver produces, and recovers the four hex digits being shown. It also reports per-digit validity, framing and error pulses. It sits beside the display path as a loop-back monitor and self-check block, and is the inverse of the hex-to-segment encoding.

Parameters:
SETTLE_CYCLES, 4, number of consecutive clocks (an, ca) must be unchanged before a capture; legal range 2..255.
CNT_W, $clog2(SETTLE_CYCLES+1), width of the stability counter; derived, not overridden.

Ports:
clk  input  1  system clock.
rst_n  input  1  reset, synchronous, active-low.
an  input  4  anode strobes, active-low; an[i]=0 selects digit i.
ca  input  7  cathode pattern, active-low; ca[6]=seg a … ca[0]=seg g.
digits  output  16  recovered nibbles; digit i at digits[4i+3:4i].
digit_valid  output  4  1 = digit i holds a decoded hex value; 0 = blank or bad.
frame_done  output  1  one-cycle pulse after all four digits captured since last pulse.
seg_err  output  1  one-cycle pulse: captured pattern is neither hex nor blank.
anode_err  output  1  one-cycle pulse: captured an has more than one zero.

Behaviour:
- Reset (synchronous, rst_n=0 at clk edge): digits=16'h0000, digit_valid=4'b0000, all pulses 0, seen=4'b0000, an_q=4'hF, ca_q=7'h7F, cnt=0. A partial frame is discarded.
- Sampling, every edge:
  - If {an,ca}=={an_q,ca_q}, cnt <= min(cnt+1, SETTLE_CYCLES); else cnt <= 0.
  - Then an_q<=an, ca_q<=ca.
- Capture condition: cnt==SETTLE_CYCLES-1. This fires exactly once per stable dwell because cnt saturates above it.
- Latency: outputs update on the (SETTLE_CYCLES+1)th rising edge at which the new value is present. For the default, that is the 5th edge.
- Capture action, evaluated on an_q/ca_q:
  - an_q==4'hF: inter-digit blanking. No change, no error.
  - an_q has exactly one zero at i, with a valid hex pattern: digits[4i+3:4i]<=nibble, digit_valid[i]<=1, seen[i]<=1.
  - Same, with pattern 7'b1111111 (blank): digit_valid[i]<=0, nibble retained, seen[i]<=1, no error.
  - Same, with any other pattern: seg_err=1 for one cycle, digit_valid[i]<=0, nibble retained, seen[i] unchanged.
  - Two or more zeros in an_q: anode_err=1 for one cycle. Nothing else changes.
- Frame: if (seen | newly seen bit)==4'hF on a capture, frame_done=1 that cycle (registered, same edge as the digit update) and seen<=0.
- Decode table, hex value : pattern: 0:0000001, 1:1001111, 2:0010010, 3:0000110, 4:1001100, 5:0100100, 6:0100000, 7:0001111, 8:0000000, 9:0000100, A:0001000, B:1100000, C:0110001, D:1000010, E:0110000, F:0111000.
- Same digit re-selected with a new stable pattern: overwrite. Duplicates do not advance the frame.
- Pulses never assert during reset or on the edge reset is released.
- Reset mid-dwell: cnt restarts from an_q=F. A steady input at release captures on edge SETTLE_CYCLES+1 after release.

Decomposition:
- Shared package sev_seg_pkg holds:
  - localparams SEG_0..SEG_F (7-bit active-low patterns above);
  - SEG_BLANK=7'b1111111;
  - NUM_DIGITS=4.
- One combinational sub-module, sev_seg_to_hex: pattern in; nibble, is_hex, is_blank out.
- All sequencing (counter, capture, seen, pulses) stays in the top module.

Test Plan:
- an=1110, ca=0000110 held 8 cycles after reset → digits[3:0]=4'h3 and digit_valid=0001 on the 5th edge; no pulses; no further updates.
- Frame, each step held 6 cycles with 2 cycles an=1111 between: an=1110/ca=0001000 (A), 1101/1100000 (B), 1011/0110001 (C), 0111/1000010 (D) → digits=16'hDCBA, digit_valid=1111, single frame_done pulse coincident with the D capture.
- Glitch: an=1011, ca=0000000 held 3 cycles, then ca=0000100 held 6 cycles → no capture of 8; digits[11:8]=4'h9 on the 5th edge of the second value.
- an=1101, ca=1111110 held 6 → seg_err one cycle, digit_valid[1]=0, digits[7:4] unchanged. Then ca=1111111 → no error, seen[1] set.
- an=1100, ca=0000001 held 6 → anode_err one cycle, digits/digit_valid/seen unchanged.
- Capture digits 0 and 1, assert rst_n=0 for one edge, then capture digits 2,3 → no frame_done. frame_done fires only after digits 0,1 are also recaptured; all outputs read 0 right after reset.

Source files
------------

// File: rtl/sev_seg_pkg.sv
// ---------------------------------------------------------------------------
// sev_seg_pkg
// Shared constants for the seven-segment scan decoder. The segment patterns
// are active-low and ordered {a,b,c,d,e,f,g}, so bit 6 is segment a and
// bit 0 is segment g.
// ---------------------------------------------------------------------------
package sev_seg_pkg;

    localparam int NUM_DIGITS = 4;

    localparam logic [6:0] SEG_0 = 7'b0000001;
    localparam logic [6:0] SEG_1 = 7'b1001111;
    localparam logic [6:0] SEG_2 = 7'b0010010;
    localparam logic [6:0] SEG_3 = 7'b0000110;
    localparam logic [6:0] SEG_4 = 7'b1001100;
    localparam logic [6:0] SEG_5 = 7'b0100100;
    localparam logic [6:0] SEG_6 = 7'b0100000;
    localparam logic [6:0] SEG_7 = 7'b0001111;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0000100;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b1100000;
    localparam logic [6:0] SEG_C = 7'b0110001;
    localparam logic [6:0] SEG_D = 7'b1000010;
    localparam logic [6:0] SEG_E = 7'b0110000;
    localparam logic [6:0] SEG_F = 7'b0111000;

    // All segments dark: a digit slot that is intentionally left blank.
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/sev_seg_to_hex.sv
// ---------------------------------------------------------------------------
// sev_seg_to_hex
// Combinational inverse of the hex-to-segment encoder.
// Ports:
//   pattern  - 7-bit active-low cathode pattern {a..g}
//   nibble   - decoded hex value (0 when the pattern is not a hex glyph)
//   is_hex   - pattern is one of the sixteen hex glyphs
//   is_blank - pattern has every segment dark
// ---------------------------------------------------------------------------
module sev_seg_to_hex
    import sev_seg_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] nibble,
    output logic       is_hex,
    output logic       is_blank
);

    always_comb begin
        nibble = 4'h0;
        is_hex = 1'b1;
        case (pattern)
            SEG_0:   nibble = 4'h0;
            SEG_1:   nibble = 4'h1;
            SEG_2:   nibble = 4'h2;
            SEG_3:   nibble = 4'h3;
            SEG_4:   nibble = 4'h4;
            SEG_5:   nibble = 4'h5;
            SEG_6:   nibble = 4'h6;
            SEG_7:   nibble = 4'h7;
            SEG_8:   nibble = 4'h8;
            SEG_9:   nibble = 4'h9;
            SEG_A:   nibble = 4'hA;
            SEG_B:   nibble = 4'hB;
            SEG_C:   nibble = 4'hC;
            SEG_D:   nibble = 4'hD;
            SEG_E:   nibble = 4'hE;
            SEG_F:   nibble = 4'hF;
            default: is_hex = 1'b0;
        endcase
    end

    assign is_blank = (pattern == SEG_BLANK);

endmodule

// File: rtl/sev_seg_scan_decoder.sv
// ---------------------------------------------------------------------------
// sev_seg_scan_decoder
// Loop-back monitor for a multiplexed four-digit seven-segment bus. Waits for
// (an, ca) to sit still for SETTLE_CYCLES clocks, then decodes the selected
// digit and reports validity, frame completion and error pulses.
// Ports:
//   clk         - system clock
//   rst_n       - synchronous active-low reset
//   an          - active-low anode strobes, an[i]=0 selects digit i
//   ca          - active-low cathode pattern, ca[6]=seg a .. ca[0]=seg g
//   digits      - recovered nibbles, digit i at digits[4i+3:4i]
//   digit_valid - digit i currently holds a decoded hex value
//   frame_done  - one-cycle pulse once all four digits have been captured
//   seg_err     - one-cycle pulse: captured pattern neither hex nor blank
//   anode_err   - one-cycle pulse: captured anode word has several zeros
// ---------------------------------------------------------------------------
module sev_seg_scan_decoder
    import sev_seg_pkg::*;
#(
    parameter  int SETTLE_CYCLES = 4,
    localparam int CNT_W         = $clog2(SETTLE_CYCLES + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_DIGITS-1:0]   an,
    input  logic [6:0]              ca,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic                    frame_done,
    output logic                    seg_err,
    output logic                    anode_err
);

    localparam logic [CNT_W-1:0] CNT_SAT     = CNT_W'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_CAPTURE = CNT_W'(SETTLE_CYCLES - 1);

    logic [NUM_DIGITS-1:0] an_q;
    logic [6:0]            ca_q;
    logic [CNT_W-1:0]      cnt;
    logic [NUM_DIGITS-1:0] seen;

    logic [3:0]            nibble;
    logic                  is_hex;
    logic                  is_blank;

    logic                  one_sel;
    logic [1:0]            sel;
    logic [NUM_DIGITS-1:0] sel_mask;
    logic                  capture;

    sev_seg_to_hex u_to_hex (
        .pattern  (ca_q),
        .nibble   (nibble),
        .is_hex   (is_hex),
        .is_blank (is_blank)
    );

    // Anything other than a single zero (including all-ones) leaves one_sel
    // low; the all-ones blanking case is separated out in the capture logic.
    always_comb begin
        one_sel = 1'b1;
        sel     = 2'd0;
        case (an_q)
            4'b1110: sel = 2'd0;
            4'b1101: sel = 2'd1;
            4'b1011: sel = 2'd2;
            4'b0111: sel = 2'd3;
            default: one_sel = 1'b0;
        endcase
        sel_mask = one_sel ? (NUM_DIGITS'(1) << sel) : '0;
    end

    // The counter saturates one above the capture value, so a long dwell
    // produces exactly one capture.
    assign capture = (cnt == CNT_CAPTURE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            digits      <= '0;
            digit_valid <= '0;
            frame_done  <= 1'b0;
            seg_err     <= 1'b0;
            anode_err   <= 1'b0;
            seen        <= '0;
            an_q        <= '1;
            ca_q        <= 7'h7F;
            cnt         <= '0;
        end else begin
            frame_done <= 1'b0;
            seg_err    <= 1'b0;
            anode_err  <= 1'b0;

            if ({an, ca} == {an_q, ca_q}) begin
                if (cnt != CNT_SAT) begin
                    cnt <= cnt + CNT_W'(1);
                end
            end else begin
                cnt <= '0;
            end
            an_q <= an;
            ca_q <= ca;

            if (capture && (an_q != '1)) begin
                if (one_sel) begin
                    if (is_hex) begin
                        digits[{sel, 2'b00} +: 4] <= nibble;
                        digit_valid[sel]          <= 1'b1;
                    end else if (is_blank) begin
                        digit_valid[sel] <= 1'b0;
                    end else begin
                        seg_err          <= 1'b1;
                        digit_valid[sel] <= 1'b0;
                    end

                    // Bad patterns do not count towards the frame.
                    if (is_hex || is_blank) begin
                        if ((seen | sel_mask) == '1) begin
                            frame_done <= 1'b1;
                            seen       <= '0;
                        end else begin
                            seen <= seen | sel_mask;
                        end
                    end
                end else begin
                    anode_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sev_seg_scan_decoder.sv
// ---------------------------------------------------------------------------
// tb_sev_seg_scan_decoder
// Directed self-checking bench for the seven-segment scan decoder.
// ---------------------------------------------------------------------------
module tb_sev_seg_scan_decoder;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  an    = 4'hF;
    logic [6:0]  ca    = 7'h7F;
    logic [15:0] digits;
    logic [3:0]  digit_valid;
    logic        frame_done;
    logic        seg_err;
    logic        anode_err;

    int checks = 0;
    int errors = 0;
    int fd_cnt = 0;
    int se_cnt = 0;
    int ae_cnt = 0;

    sev_seg_scan_decoder #(.SETTLE_CYCLES(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .an          (an),
        .ca          (ca),
        .digits      (digits),
        .digit_valid (digit_valid),
        .frame_done  (frame_done),
        .seg_err     (seg_err),
        .anode_err   (anode_err)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic hold(input logic [3:0] a, input logic [6:0] c, input int n);
        an = a;
        ca = c;
        repeat (n) begin
            @(posedge clk);
            #1;
            if (frame_done) fd_cnt++;
            if (seg_err)    se_cnt++;
            if (anode_err)  ae_cnt++;
        end
    endtask

    task automatic clear_counts();
        fd_cnt = 0;
        se_cnt = 0;
        ae_cnt = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        hold(4'hF, 7'h7F, 2);
        rst_n = 1'b1;
        clear_counts();
    endtask

    function automatic logic [3:0] an_for(input int i);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << i);
    endfunction

    // Hold a digit long enough to capture, then blank for two clocks.
    task automatic capture(input int i, input logic [6:0] c);
        hold(an_for(i), c, 6);
        hold(4'hF, 7'h7F, 2);
    endtask

    task automatic test_reset();
        $display("[TB] test_reset");
        rst_n = 1'b0;
        clear_counts();
        hold(4'b1110, 7'b0000110, 3);
        checks++;
        if (digits !== 16'h0000 || digit_valid !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got digits=%h valid=%b expected 0000/0000", digits, digit_valid);
        end
        checks++;
        if (fd_cnt + se_cnt + ae_cnt != 0) begin
            errors++;
            $display("[TB] FAIL reset_pulses: got %0d pulses expected 0", fd_cnt + se_cnt + ae_cnt);
        end
        // Steady input across release captures on the 5th edge after release.
        rst_n = 1'b1;
        hold(4'b1110, 7'b0000110, 4);
        checks++;
        if (digit_valid !== 4'b0000 || fd_cnt + se_cnt + ae_cnt != 0) begin
            errors++;
            $display("[TB] FAIL release_early: got valid=%b pulses=%0d expected 0000/0", digit_valid, fd_cnt + se_cnt + ae_cnt);
        end
        hold(4'b1110, 7'b0000110, 1);
        checks++;
        if (digits !== 16'h0003 || digit_valid !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL release_capture: got %h/%b expected 0003/0001", digits, digit_valid);
        end
    endtask

    task automatic test_single_digit();
        $display("[TB] test_single_digit");
        do_reset();
        hold(4'b1110, 7'b0000110, 4);
        checks++;
        if (digit_valid !== 4'b0000 || digits !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL single_early: got %h/%b expected 0000/0000", digits, digit_valid);
        end
        hold(4'b1110, 7'b0000110, 1);
        checks++;
        if (digits !== 16'h0003 || digit_valid !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL single_capture: got %h/%b expected 0003/0001", digits, digit_valid);
        end
        hold(4'b1110, 7'b0000110, 3);
        checks++;
        if (digits !== 16'h0003 || digit_valid !== 4'b0001 || fd_cnt + se_cnt + ae_cnt != 0) begin
            errors++;
            $display("[TB] FAIL single_hold: got %h/%b pulses=%0d expected 0003/0001/0", digits, digit_valid, fd_cnt + se_cnt + ae_cnt);
        end
    endtask

    task automatic test_frame();
        $display("[TB] test_frame");
        do_reset();
        capture(0, 7'b0001000);
        capture(1, 7'b1100000);
        capture(2, 7'b0110001);
        hold(4'b0111, 7'b1000010, 4);
        checks++;
        if (fd_cnt != 0) begin
            errors++;
            $display("[TB] FAIL frame_early: got %0d pulses expected 0", fd_cnt);
        end
        hold(4'b0111, 7'b1000010, 1);
        checks++;
        if (frame_done !== 1'b1 || digits !== 16'hDCBA || digit_valid !== 4'b1111) begin
            errors++;
            $display("[TB] FAIL frame_capture: got fd=%b %h/%b expected 1 DCBA/1111", frame_done, digits, digit_valid);
        end
        hold(4'b0111, 7'b1000010, 1);
        hold(4'hF, 7'h7F, 2);
        checks++;
        if (fd_cnt != 1 || se_cnt + ae_cnt != 0) begin
            errors++;
            $display("[TB] FAIL frame_pulses: got fd=%0d err=%0d expected 1/0", fd_cnt, se_cnt + ae_cnt);
        end
    endtask

    task automatic test_glitch();
        $display("[TB] test_glitch");
        do_reset();
        hold(4'b1011, 7'b0000000, 3);
        hold(4'b1011, 7'b0000100, 4);
        checks++;
        if (digits !== 16'h0000 || digit_valid !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL glitch_early: got %h/%b expected 0000/0000", digits, digit_valid);
        end
        hold(4'b1011, 7'b0000100, 1);
        checks++;
        if (digits !== 16'h0900 || digit_valid !== 4'b0100) begin
            errors++;
            $display("[TB] FAIL glitch_capture: got %h/%b expected 0900/0100", digits, digit_valid);
        end
    endtask

    task automatic test_seg_err();
        $display("[TB] test_seg_err");
        do_reset();
        capture(1, 7'b0100100);
        capture(0, 7'b0000001);
        capture(2, 7'b0010010);
        capture(3, 7'b0000110);
        checks++;
        if (fd_cnt != 1 || digits !== 16'h3250 || digit_valid !== 4'b1111) begin
            errors++;
            $display("[TB] FAIL seg_setup: got fd=%0d %h/%b expected 1 3250/1111", fd_cnt, digits, digit_valid);
        end
        clear_counts();
        capture(0, 7'b0000001);
        capture(2, 7'b0010010);
        capture(3, 7'b0000110);
        hold(4'b1101, 7'b1111110, 4);
        checks++;
        if (se_cnt != 0 || fd_cnt != 0) begin
            errors++;
            $display("[TB] FAIL seg_early: got se=%0d fd=%0d expected 0/0", se_cnt, fd_cnt);
        end
        hold(4'b1101, 7'b1111110, 1);
        checks++;
        if (seg_err !== 1'b1 || digit_valid !== 4'b1101 || digits !== 16'h3250) begin
            errors++;
            $display("[TB] FAIL seg_capture: got se=%b %h/%b expected 1 3250/1101", seg_err, digits, digit_valid);
        end
        hold(4'b1101, 7'b1111110, 1);
        hold(4'hF, 7'h7F, 2);
        checks++;
        if (se_cnt != 1 || fd_cnt != 0) begin
            errors++;
            $display("[TB] FAIL seg_pulse: got se=%0d fd=%0d expected 1/0", se_cnt, fd_cnt);
        end
        // A blank on digit 1 counts as seen and completes the frame.
        hold(4'b1101, 7'b1111111, 6);
        checks++;
        if (se_cnt != 1 || fd_cnt != 1 || digit_valid !== 4'b1101 || digits !== 16'h3250) begin
            errors++;
            $display("[TB] FAIL seg_blank: got se=%0d fd=%0d %h/%b expected 1/1 3250/1101", se_cnt, fd_cnt, digits, digit_valid);
        end
    endtask

    task automatic test_anode_err();
        $display("[TB] test_anode_err");
        do_reset();
        capture(0, 7'b0001111);
        capture(1, 7'b0110000);
        hold(4'b1100, 7'b0000001, 4);
        checks++;
        if (ae_cnt != 0) begin
            errors++;
            $display("[TB] FAIL anode_early: got %0d expected 0", ae_cnt);
        end
        hold(4'b1100, 7'b0000001, 1);
        checks++;
        if (anode_err !== 1'b1 || digits !== 16'h00E7 || digit_valid !== 4'b0011) begin
            errors++;
            $display("[TB] FAIL anode_capture: got ae=%b %h/%b expected 1 00E7/0011", anode_err, digits, digit_valid);
        end
        hold(4'b1100, 7'b0000001, 1);
        hold(4'hF, 7'h7F, 2);
        checks++;
        if (ae_cnt != 1 || fd_cnt != 0 || se_cnt != 0) begin
            errors++;
            $display("[TB] FAIL anode_pulse: got ae=%0d fd=%0d se=%0d expected 1/0/0", ae_cnt, fd_cnt, se_cnt);
        end
        capture(2, 7'b1001111);
        hold(4'b0111, 7'b0000000, 5);
        checks++;
        if (frame_done !== 1'b1 || fd_cnt != 1 || digits !== 16'h81E7) begin
            errors++;
            $display("[TB] FAIL anode_frame: got fd=%b cnt=%0d %h expected 1/1 81E7", frame_done, fd_cnt, digits);
        end
    endtask

    task automatic test_back_to_back();
        $display("[TB] test_back_to_back");
        do_reset();
        hold(4'b1110, 7'b1001111, 6);
        hold(4'b1110, 7'b0010010, 6);
        checks++;
        if (digits !== 16'h0002 || digit_valid !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL b2b_overwrite: got %h/%b expected 0002/0001", digits, digit_valid);
        end
        hold(4'hF, 7'h7F, 2);
        capture(1, 7'b1001100);
        capture(2, 7'b0100000);
        checks++;
        if (fd_cnt != 0 || digits !== 16'h0642) begin
            errors++;
            $display("[TB] FAIL b2b_dup: got fd=%0d %h expected 0 0642", fd_cnt, digits);
        end
        capture(3, 7'b0111000);
        checks++;
        if (fd_cnt != 1 || digits !== 16'hF642 || digit_valid !== 4'b1111) begin
            errors++;
            $display("[TB] FAIL b2b_frame: got fd=%0d %h/%b expected 1 F642/1111", fd_cnt, digits, digit_valid);
        end
    endtask

    task automatic test_reset_frame();
        $display("[TB] test_reset_frame");
        do_reset();
        capture(0, 7'b0000100);
        capture(1, 7'b0001000);
        checks++;
        if (digit_valid !== 4'b0011 || digits !== 16'h00A9) begin
            errors++;
            $display("[TB] FAIL rf_setup: got %h/%b expected 00A9/0011", digits, digit_valid);
        end
        rst_n = 1'b0;
        clear_counts();
        hold(4'hF, 7'h7F, 1);
        checks++;
        if (digits !== 16'h0000 || digit_valid !== 4'b0000 || frame_done !== 1'b0 || seg_err !== 1'b0 || anode_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rf_reset: got %h/%b fd=%b se=%b ae=%b expected all zero", digits, digit_valid, frame_done, seg_err, anode_err);
        end
        rst_n = 1'b1;
        capture(2, 7'b1100000);
        capture(3, 7'b0110001);
        checks++;
        if (fd_cnt != 0 || digits !== 16'hCB00) begin
            errors++;
            $display("[TB] FAIL rf_partial: got fd=%0d %h expected 0 CB00", fd_cnt, digits);
        end
        capture(0, 7'b1000010);
        hold(4'b1101, 7'b0110000, 4);
        checks++;
        if (fd_cnt != 0) begin
            errors++;
            $display("[TB] FAIL rf_early: got fd=%0d expected 0", fd_cnt);
        end
        hold(4'b1101, 7'b0110000, 1);
        checks++;
        if (frame_done !== 1'b1 || digits !== 16'hCBED || digit_valid !== 4'b1111) begin
            errors++;
            $display("[TB] FAIL rf_frame: got fd=%b %h/%b expected 1 CBED/1111", frame_done, digits, digit_valid);
        end
    endtask

    initial begin
        test_reset();
        test_single_digit();
        test_frame();
        test_glitch();
        test_seg_err();
        test_anode_err();
        test_back_to_back();
        test_reset_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
